// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC sequencer: arbitrates sequential, pc_gen (early) and ALU (late) redirects, drives front/back-end flushes.
// Optional redirect statistics counters are built when PC_CTRL_STATS_EN is defined.
module fetch_redirect_ctrl #(
    parameter int unsigned        xlen         = 32,
    parameter logic [xlen-1:0]    RESET_PC     = '0,
    parameter int unsigned        FLUSH_CYCLES = 2
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    output logic [xlen-1:0] pc_o,
    output logic            pc_valid_o,
    input  logic            if_ready_i,
    input  logic            pg_target_valid_i,
    input  logic [xlen-1:0] pg_target_i,
    input  logic            alu_target_valid_i,
    input  logic [xlen-1:0] alu_target_i,
    output logic            flush_if_o,
    output logic            flush_be_o,
    output logic [31:0]     stat_alu_redirects_o,
    output logic [31:0]     stat_pg_redirects_o
);

    // state | meaning
    // BOOT  | first cycle after reset, no fetch request
    // RUN   | presenting pc to ifetch, accepting redirects
    // FLUSH | back-end flush in progress, fetch stalled
    typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_e;

    localparam logic [3:0] FCNT_LOAD = 4'(FLUSH_CYCLES - 1);
    // A single-cycle flush needs no FLUSH state: flush_be is still a registered one-cycle pulse.
    localparam state_e ALU_NEXT = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

    state_e          state_q, state_d;
    logic [xlen-1:0] pc_q, pc_d;
    logic [3:0]      fcnt_q, fcnt_d;
    logic            flush_if_q, flush_if_d;
    logic            flush_be_q, flush_be_d;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            fcnt_q     <= '0;
            flush_if_q <= 1'b0;
            flush_be_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fcnt_q     <= fcnt_d;
            flush_if_q <= flush_if_d;
            flush_be_q <= flush_be_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fcnt_d     = fcnt_q;
        flush_if_d = 1'b0;
        flush_be_d = 1'b0;
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (alu_target_valid_i) begin
                    pc_d       = {alu_target_i[xlen-1:2], 2'b00};
                    flush_if_d = 1'b1;
                    flush_be_d = 1'b1;
                    fcnt_d     = FCNT_LOAD;
                    state_d    = ALU_NEXT;
                end else if (pg_target_valid_i) begin
                    pc_d       = {pg_target_i[xlen-1:2], 2'b00};
                    flush_if_d = 1'b1;
                end else if (if_ready_i) begin
                    pc_d = pc_q + xlen'(4);
                end
            end
            FLUSH: begin
                flush_be_d = 1'b1;
                if (alu_target_valid_i) begin
                    pc_d       = {alu_target_i[xlen-1:2], 2'b00};
                    flush_if_d = 1'b1;
                    fcnt_d     = FCNT_LOAD;
                end else if (fcnt_q == 4'd0) begin
                    state_d    = RUN;
                    flush_be_d = 1'b0;
                end else begin
                    fcnt_d = fcnt_q - 4'd1;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        pc_o       = pc_q;
        pc_valid_o = (state_q == RUN);
        flush_if_o = flush_if_q;
        flush_be_o = flush_be_q;
    end

`ifdef PC_CTRL_STATS_EN
    logic        alu_acc, pg_acc;
    logic [31:0] stat_alu_q, stat_pg_q;

    assign alu_acc = alu_target_valid_i && (state_q == RUN || state_q == FLUSH);
    assign pg_acc  = pg_target_valid_i && !alu_target_valid_i && (state_q == RUN);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            stat_alu_q <= '0;
            stat_pg_q  <= '0;
        end else begin
            if (alu_acc && stat_alu_q != 32'hFFFF_FFFF) stat_alu_q <= stat_alu_q + 32'd1;
            if (pg_acc && stat_pg_q != 32'hFFFF_FFFF)   stat_pg_q  <= stat_pg_q + 32'd1;
        end
    end

    assign stat_alu_redirects_o = stat_alu_q;
    assign stat_pg_redirects_o  = stat_pg_q;
`else
    assign stat_alu_redirects_o = 32'd0;
    assign stat_pg_redirects_o  = 32'd0;
`endif

endmodule
